// File: rtl/fm_radio_pkg.sv
// Shared FM receiver constants, channel filter coefficients, sequencer states and product dequantizer.
// FIR_SCHED_ROUND_EN selects round-half-up dequantization; undefined gives plain truncation.
package fm_radio_pkg;

   localparam int DATA_SIZE = 32;
   localparam int BITS      = 10;
   localparam int TAPS      = 20;

   // Channel filter taps quantized with BITS fractional bits (1.0 == 1024).
   localparam logic signed [DATA_SIZE-1:0] CHANNEL_COEFFS [TAPS] = '{
      32'sd512, -32'sd30, -32'sd20,  32'sd10,  32'sd40,
       32'sd80,  32'sd120, 32'sd160, 32'sd190, 32'sd200,
       32'sd200, 32'sd190, 32'sd160, 32'sd120, 32'sd80,
       32'sd40,  32'sd10, -32'sd20, -32'sd30, -32'sd10
   };

   typedef enum logic [1:0] {
      S_FILL,
      S_MAC_I,
      S_MAC_Q,
      S_WRITE
   } sched_state_t;

`ifdef FIR_SCHED_ROUND_EN
   localparam logic signed [2*DATA_SIZE-1:0] DEQ_HALF = (2*DATA_SIZE)'(1) <<< (BITS-1);
`endif

   function automatic logic signed [DATA_SIZE-1:0] deq(input logic signed [2*DATA_SIZE-1:0] p);
      logic signed [2*DATA_SIZE-1:0] t;
`ifdef FIR_SCHED_ROUND_EN
      t = (p + DEQ_HALF) >>> BITS;
`else
      t = p >>> BITS;
`endif
      return t[DATA_SIZE-1:0];
   endfunction

endpackage

// File: rtl/iq_mac.sv
// Shared multiply / dequantize / accumulate unit; clear restarts the sum (with the current term when acc_en is also high).
module iq_mac
   import fm_radio_pkg::*;
(
   input  logic                        clock,
   input  logic                        reset,
   input  logic signed [DATA_SIZE-1:0] sample,
   input  logic signed [DATA_SIZE-1:0] coeff,
   input  logic                        acc_en,
   input  logic                        clear,
   output logic signed [DATA_SIZE-1:0] sum
);

   logic signed [2*DATA_SIZE-1:0] prod;
   logic signed [DATA_SIZE-1:0]   term;

   assign prod = (2*DATA_SIZE)'(sample) * (2*DATA_SIZE)'(coeff);
   assign term = acc_en ? deq(prod) : '0;

   // Accumulation wraps modulo 2^DATA_SIZE on purpose; no saturation.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sum <= '0;
      end else if (clear) begin
         sum <= term;
      end else if (acc_en) begin
         sum <= sum + term;
      end
   end

endmodule

// File: rtl/iq_fir_scheduler.sv
// Complex channel FIR scheduler: pops I/Q pairs into per-lane histories, runs one shared MAC over I then Q, pushes the pair.
// Dequantization rounding follows FIR_SCHED_ROUND_EN (defined in fm_radio_pkg's deq).
//
// state    | meaning
// S_FILL   | popping input pairs until DECIM have arrived
// S_MAC_I  | one I-lane tap per cycle through the shared MAC
// S_MAC_Q  | one Q-lane tap per cycle; I result latched on tap 0
// S_WRITE  | presenting the result pair until both output FIFOs accept it
module iq_fir_scheduler #(
   parameter int DATA_SIZE = fm_radio_pkg::DATA_SIZE,
   parameter int BITS      = fm_radio_pkg::BITS,
   parameter int TAPS      = fm_radio_pkg::TAPS,
   parameter int DECIM     = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 i_in_empty,
   input  logic                 q_in_empty,
   input  logic [DATA_SIZE-1:0] i_in_dout,
   input  logic [DATA_SIZE-1:0] q_in_dout,
   output logic                 i_in_rd_en,
   output logic                 q_in_rd_en,
   input  logic                 i_out_full,
   input  logic                 q_out_full,
   output logic                 i_out_wr_en,
   output logic                 q_out_wr_en,
   output logic [DATA_SIZE-1:0] i_out_din,
   output logic [DATA_SIZE-1:0] q_out_din
);

   import fm_radio_pkg::*;

   // The MAC and coefficient table are built from the package, so the parameters must agree with it.
   if (DATA_SIZE != fm_radio_pkg::DATA_SIZE || BITS != fm_radio_pkg::BITS ||
       TAPS != fm_radio_pkg::TAPS || TAPS < 2 || DECIM < 1) begin : g_param_chk
      $error("iq_fir_scheduler: parameters inconsistent with fm_radio_pkg or out of range");
   end

   localparam int KW = $clog2(TAPS);
   localparam int FW = (DECIM > 1) ? $clog2(DECIM) : 1;

   sched_state_t state, state_nxt;
   logic [KW-1:0] k;
   logic [FW-1:0] fill_cnt;
   logic signed [DATA_SIZE-1:0] hist_i [TAPS];
   logic signed [DATA_SIZE-1:0] hist_q [TAPS];
   logic signed [DATA_SIZE-1:0] acc_i;
   logic signed [DATA_SIZE-1:0] mac_sum;
   logic signed [DATA_SIZE-1:0] mac_sample;
   logic signed [DATA_SIZE-1:0] mac_coeff;
   logic pop, wr, mac_en, mac_clr, last_tap, fill_last;

   assign last_tap  = (k == KW'(TAPS-1));
   assign fill_last = (fill_cnt == FW'(DECIM-1));
   assign mac_coeff = CHANNEL_COEFFS[k];

   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      wr         = 1'b0;
      mac_en     = 1'b0;
      mac_clr    = 1'b0;
      mac_sample = hist_i[k];
      case (state)
         S_FILL: begin
            pop = !i_in_empty && !q_in_empty;
            if (pop && fill_last) begin
               mac_clr   = 1'b1;
               state_nxt = S_MAC_I;
            end
         end
         S_MAC_I: begin
            mac_en = 1'b1;
            if (last_tap) state_nxt = S_MAC_Q;
         end
         S_MAC_Q: begin
            mac_en     = 1'b1;
            mac_sample = hist_q[k];
            mac_clr    = (k == '0);
            if (last_tap) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            wr = !i_out_full && !q_out_full;
            if (wr) state_nxt = S_FILL;
         end
         default: state_nxt = S_FILL;
      endcase
   end

   // Strobes are gated by reset so every output reads 0 while reset is held.
   assign i_in_rd_en  = pop && reset;
   assign q_in_rd_en  = pop && reset;
   assign i_out_wr_en = wr;
   assign q_out_wr_en = wr;
   assign i_out_din   = acc_i;
   assign q_out_din   = mac_sum;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_FILL;
         k        <= '0;
         fill_cnt <= '0;
         acc_i    <= '0;
         for (int j = 0; j < TAPS; j++) begin
            hist_i[j] <= '0;
            hist_q[j] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (pop) begin
            for (int j = TAPS-1; j > 0; j--) begin
               hist_i[j] <= hist_i[j-1];
               hist_q[j] <= hist_q[j-1];
            end
            hist_i[0] <= i_in_dout;
            hist_q[0] <= q_in_dout;
            fill_cnt  <= fill_last ? '0 : fill_cnt + FW'(1);
         end
         if (pop && fill_last) begin
            k     <= '0;
            acc_i <= '0;
         end else if (mac_en) begin
            k <= last_tap ? '0 : k + KW'(1);
         end
         // The shared MAC holds the finished I sum on the first Q tap.
         if (state == S_MAC_Q && k == '0) acc_i <= mac_sum;
      end
   end

   iq_mac u_mac (
      .clock  (clock),
      .reset  (reset),
      .sample (mac_sample),
      .coeff  (mac_coeff),
      .acc_en (mac_en),
      .clear  (mac_clr),
      .sum    (mac_sum)
   );

endmodule

// File: tb/tb_iq_fir_scheduler.sv
// Scoreboard bench for iq_fir_scheduler: one DECIM=1 and one DECIM=4 instance fed from queue-backed FIFO models.
module tb_iq_fir_scheduler;
   import fm_radio_pkg::*;

   localparam int W = 32;
   // Hand-entered channel taps (1.0 == 1024); impulse response of the filter.
   localparam int COEF [20] = '{512, -30, -20, 10, 40, 80, 120, 160, 190, 200,
                                200, 190, 160, 120, 80, 40, 10, -20, -30, -10};
`ifdef FIR_SCHED_ROUND_EN
   localparam int ROUND_EXP = 1;
`else
   localparam int ROUND_EXP = 0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic e1_i, e1_q, rd1_i, rd1_q, f1_i, f1_q, wr1_i, wr1_q;
   logic [W-1:0] d1_i, d1_q, o1_i, o1_q;
   logic e4_i, e4_q, rd4_i, rd4_q, f4_i, f4_q, wr4_i, wr4_q;
   logic [W-1:0] d4_i, d4_q, o4_i, o4_q;

   logic [W-1:0] iq1[$], qq1[$], iq4[$], qq4[$];
   logic [W-1:0] x1_i[$], x1_q[$], x4_i[$], x4_q[$];
   logic rd1_seen = 1'b0, rd4_seen = 1'b0;
   int last1 = -1, last4 = -1, period1 = 0, period4 = 0;

   iq_fir_scheduler #(.DECIM(1)) d1 (
      .clock(clock), .reset(reset),
      .i_in_empty(e1_i), .q_in_empty(e1_q), .i_in_dout(d1_i), .q_in_dout(d1_q),
      .i_in_rd_en(rd1_i), .q_in_rd_en(rd1_q), .i_out_full(f1_i), .q_out_full(f1_q),
      .i_out_wr_en(wr1_i), .q_out_wr_en(wr1_q), .i_out_din(o1_i), .q_out_din(o1_q));

   iq_fir_scheduler #(.DECIM(4)) d4 (
      .clock(clock), .reset(reset),
      .i_in_empty(e4_i), .q_in_empty(e4_q), .i_in_dout(d4_i), .q_in_dout(d4_q),
      .i_in_rd_en(rd4_i), .q_in_rd_en(rd4_q), .i_out_full(f4_i), .q_out_full(f4_q),
      .i_out_wr_en(wr4_i), .q_out_wr_en(wr4_q), .i_out_din(o4_i), .q_out_din(o4_q));

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // FIFO models: pop after the edge that consumed the head, then refresh flags and head data.
   always @(posedge clock) begin
      logic [W-1:0] tmp;
      #1;
      if (rd1_seen && iq1.size() > 0 && qq1.size() > 0) begin
         tmp = iq1.pop_front(); tmp = qq1.pop_front();
      end
      if (rd4_seen && iq4.size() > 0 && qq4.size() > 0) begin
         tmp = iq4.pop_front(); tmp = qq4.pop_front();
      end
      e1_i = (iq1.size() == 0); d1_i = (iq1.size() > 0) ? iq1[0] : '0;
      e1_q = (qq1.size() == 0); d1_q = (qq1.size() > 0) ? qq1[0] : '0;
      e4_i = (iq4.size() == 0); d4_i = (iq4.size() > 0) ? iq4[0] : '0;
      e4_q = (qq4.size() == 0); d4_q = (qq4.size() > 0) ? qq4[0] : '0;
   end

   // Monitors: compare every presented write against the scoreboard.
   always @(negedge clock) begin
      logic [W-1:0] ei, eq;
      rd1_seen = rd1_i;
      if (reset) begin
         chk("rd_pair_d1", rd1_q, rd1_i);
         chk("wr_pair_d1", wr1_q, wr1_i);
         if (wr1_i) begin
            if (x1_i.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write_d1 actual i=%0h q=%0h required none", o1_i, o1_q);
            end else begin
               ei = x1_i.pop_front(); eq = x1_q.pop_front();
               chk("i_out_d1", o1_i, ei);
               chk("q_out_d1", o1_q, eq);
               if (period1 != 0 && last1 >= 0) chk("period_d1", W'(cyc - last1), W'(period1));
               last1 = cyc;
            end
         end
      end
   end

   always @(negedge clock) begin
      logic [W-1:0] ei, eq;
      rd4_seen = rd4_i;
      if (reset) begin
         chk("rd_pair_d4", rd4_q, rd4_i);
         chk("wr_pair_d4", wr4_q, wr4_i);
         if (wr4_i) begin
            if (x4_i.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write_d4 actual i=%0h q=%0h required none", o4_i, o4_q);
            end else begin
               ei = x4_i.pop_front(); eq = x4_q.pop_front();
               chk("i_out_d4", o4_i, ei);
               chk("q_out_d4", o4_q, eq);
               if (period4 != 0 && last4 >= 0) chk("period_d4", W'(cyc - last4), W'(period4));
               last4 = cyc;
            end
         end
      end
   end

   task automatic clear_all();
      iq1.delete(); qq1.delete(); iq4.delete(); qq4.delete();
      x1_i.delete(); x1_q.delete(); x4_i.delete(); x4_q.delete();
      last1 = -1; last4 = -1; period1 = 0; period4 = 0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_rd_d1", rd1_i, 1'b0);  chk("rst_wr_d1", wr1_i, 1'b0);
      chk("rst_i_d1", o1_i, '0);      chk("rst_q_d1", o1_q, '0);
      chk("rst_state_d1", W'(d1.state), W'(S_FILL));
      chk("rst_rd_d4", rd4_i, 1'b0);  chk("rst_wr_d4", wr4_i, 1'b0);
      chk("rst_i_d4", o4_i, '0);      chk("rst_q_d4", o4_q, '0);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      clear_all();
      repeat (3) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((x1_i.size() != 0 || x4_i.size() != 0) && n < budget) begin
         @(negedge clock); #1;
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout actual pending=%0d/%0d required 0/0", name, x1_i.size(), x4_i.size());
      end
   endtask

   task automatic push_impulse_d1();
      for (int j = 0; j < 20; j++) begin
         iq1.push_back((j == 0) ? 32'h0000_0400 : 32'h0);
         qq1.push_back(32'h0);
         x1_i.push_back(W'(COEF[j]));
         x1_q.push_back(32'h0);
      end
   endtask

   task automatic wait_state_d1(input string name, input sched_state_t s, input int kk, input int budget);
      int n = 0;
      while (!(d1.state == s && (kk < 0 || int'(d1.k) == kk)) && n < budget) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout actual state=%0d k=%0d required state=%0d", name, d1.state, d1.k, s);
      end
   endtask

   initial begin
      f1_i = 1'b0; f1_q = 1'b0; f4_i = 1'b0; f4_q = 1'b0;
      clear_all();

      // Impulse on d1 and Q step on d4, queued while reset holds so the pop strobes must stay low.
      push_impulse_d1();
      for (int j = 0; j < 80; j++) begin
         iq4.push_back(32'h0);
         qq4.push_back(32'h0000_0400);
      end
      x4_q.push_back(32'd472);  x4_q.push_back(32'd872);
      x4_q.push_back(32'd1652); x4_q.push_back(32'd2052);
      for (int j = 0; j < 16; j++) x4_q.push_back(32'd2002);
      for (int j = 0; j < 20; j++) x4_i.push_back(32'h0);
      period1 = 42;
      period4 = 45;
      repeat (3) @(negedge clock);
      check_reset_outputs();
      reset = 1'b1;
      wait_drain("impulse_and_step", 1500);
      period1 = 0; period4 = 0;

      // Lane skew: I has data, Q is empty.
      repeat (2) @(negedge clock);
      for (int j = 0; j < 50; j++) iq1.push_back(32'h0000_0123);
      repeat (2) @(negedge clock);
      for (int j = 0; j < 50; j++) begin
         @(negedge clock); #1;
         chk("skew_rd", rd1_i, 1'b0);
         chk("skew_wr", wr1_i, 1'b0);
         chk("skew_state", W'(d1.state), W'(S_FILL));
      end

      // Backpressure on the I output FIFO.
      pulse_reset();
      f1_i = 1'b1;
      iq1.push_back(32'h0000_0400); qq1.push_back(32'h0);
      x1_i.push_back(32'd512);     x1_q.push_back(32'h0);
      wait_state_d1("reach_write", S_WRITE, -1, 100);
      for (int j = 0; j < 30; j++) begin
         @(negedge clock); #1;
         chk("bp_wr", wr1_i, 1'b0);
         chk("bp_i_din", o1_i, 32'd512);
         chk("bp_q_din", o1_q, 32'h0);
         chk("bp_state", W'(d1.state), W'(S_WRITE));
      end
      @(posedge clock); #1;
      f1_i = 1'b0;
      @(negedge clock); #1;
      chk("bp_release_wr", wr1_i, 1'b1);
      @(negedge clock); #1;
      chk("bp_single_wr", wr1_i, 1'b0);
      chk("bp_after_state", W'(d1.state), W'(S_FILL));
      wait_drain("backpressure", 50);

      // Reset in the middle of the Q-lane MAC, then the impulse must reproduce exactly.
      push_impulse_d1();
      wait_state_d1("reach_mac_q_k7", S_MAC_Q, 7, 200);
      reset = 1'b0;
      #1;
      check_reset_outputs();
      chk("midmac_k", W'(d1.k), '0);
      clear_all();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      push_impulse_d1();
      period1 = 42;
      wait_drain("impulse_after_reset", 1000);
      period1 = 0;

      // Rounding: 1 * 0.5 lands exactly on the half LSB.
      iq1.push_back(32'h1); qq1.push_back(32'h1);
      x1_i.push_back(W'(ROUND_EXP)); x1_q.push_back(W'(ROUND_EXP));
      wait_drain("rounding", 100);
      repeat (3) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iq_fir_scheduler.md
# iq_fir_scheduler

Schedules the complex channel filter that follows read_iq in the FM receiver chain. Pops I/Q sample pairs in lockstep from the read_iq output FIFOs and keeps a TAPS-deep history per lane. Every DECIM pops, it time-multiplexes one shared multiply/dequantize/accumulate unit across the I lane and then the Q lane. It then writes the filtered pair into the downstream I and Q FIFOs.

## Interface
- DATA_SIZE, 32, sample/coefficient/accumulator width (signed, fixed point)
- BITS, 10, fractional bits; products are dequantized by BITS
- TAPS, 20, filter length, ≥2
- DECIM, 1, input pairs consumed per output pair, ≥1
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_in_empty, q_in_empty  in  1  input FIFO empty flags (first-word-fall-through)
- i_in_dout, q_in_dout  in  DATA_SIZE  input FIFO head data
- i_in_rd_en, q_in_rd_en  out  1  input pop strobes, always equal to each other
- i_out_full, q_out_full  in  1  output FIFO full flags
- i_out_wr_en, q_out_wr_en  out  1  output push strobes, always equal to each other
- i_out_din, q_out_din  out  DATA_SIZE  filtered samples

## Operation
- States: S_FILL, S_MAC_I, S_MAC_Q, S_WRITE. Reset state is S_FILL.
- S_FILL: rd_en = (state==S_FILL) && !i_in_empty && !q_in_empty, combinational. Never pop one lane alone.
- On each pop, shift the input into index 0 of each lane's history, drop index TAPS-1, and increment fill_cnt.
- When the pop brings fill_cnt to DECIM: clear fill_cnt, clear both accumulators, clear tap index k, go to S_MAC_I.
- S_MAC_I: one tap per cycle, k = 0..TAPS-1, acc_i += deq(hist_i[k] * COEFFS[k]). After k = TAPS-1, go to S_MAC_Q with k = 0.
- S_MAC_Q: same as S_MAC_I using hist_q and acc_q, then go to S_WRITE.
- S_WRITE: wr_en = !i_out_full && !q_out_full. While either FIFO is full, hold state with din stable. On the write, go to S_FILL.
- i_out_din / q_out_din are registered copies of acc_i / acc_q. They are driven throughout S_WRITE.
- Arithmetic: full 2·DATA_SIZE signed product; deq(p) = p >>> BITS truncated to DATA_SIZE; accumulation wraps modulo 2^DATA_SIZE, no saturation.
- Reset (any time, including mid-MAC) clears state, fill_cnt, k, both histories, both accumulators and the output registers. All outputs are 0 during reset.

## Timing
- Pop to first MAC cycle: 1 cycle. A pair is popped at most once per cycle.
- Minimum period per output pair: DECIM + 2·TAPS + 1 cycles. With defaults this is 42.
- Output is written in the cycle after S_MAC_Q completes, provided neither output FIFO is full.
- No input pops occur in S_MAC_I, S_MAC_Q or S_WRITE. The upstream FIFOs absorb the backlog.
- If one input FIFO is non-empty and the other is empty, nothing is popped. The block waits with no timeout.
- Both output FIFOs going not-full on the same edge: write on that cycle.

## Configuration
- FIR_SCHED_ROUND_EN defined: deq(p) = (p + 2^(BITS−1)) >>> BITS (round half up).
- FIR_SCHED_ROUND_EN undefined: truncating arithmetic shift only. This matches the software reference model output files.

## Structure
- Shared package fm_radio_pkg holds:
  - DATA_SIZE, BITS, TAPS
  - CHANNEL_COEFFS[TAPS] (quantized)
  - the deq function
  - the sched_state_t enum
- One sub-module: iq_mac. It takes a sample, a coefficient, an accumulate enable and a clear, and returns the dequantized running sum. It is instantiated once and muxed between lanes.

## Test plan
- Impulse, DECIM=1: I = 0x00000400 (1.0), then 19 zeros; Q all zero. Required: i_out sequence equals CHANNEL_COEFFS[0..19] in order; q_out all 0x00000000.
- Step on Q, DECIM=4: 80 Q pairs of 0x00000400, I zero. Required: 20 outputs; q_out reaches the sum of CHANNEL_COEFFS (truncated) from output 5 onward.
- Lane skew: i_in_empty=0, q_in_empty=1 for 50 cycles. Required: rd_en stays 0, state stays S_FILL, no writes.
- Backpressure: i_out_full held 1 for 30 cycles in S_WRITE. Required: wr_en=0, din stable; a single write one cycle after full drops.
- Mid-MAC reset: assert reset at k=7 of S_MAC_Q. Required: all outputs 0 and state S_FILL. The next impulse test after release reproduces the impulse results exactly.
- Rounding: input 0x00000001 with coefficient 0x00000200 (0.5). Required: out 0x00000000 without FIR_SCHED_ROUND_EN; out 0x00000001 with it.
